prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 17 +
 rtl/lfsr_core.sv | 33 +++
 rtl/prbs_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared state encoding, default LFSR constants and sizing helper for the PRBS checker
package prbs_pkg;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int                   DEF_WIDTH    = 4;
    localparam logic [DEF_WIDTH-1:0] DEF_TAP_MASK = 4'b1001;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - predictor shift register with tap XOR and si/feedback load select
module lfsr_core
    import prbs_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK = DEF_TAP_MASK
) (
    input  logic clk,
    input  logic rst,
    input  logic i_adv,
    input  logic i_use_pred,
    input  logic i_si,
    output logic o_pred,
    output logic o_zero
);

    logic [WIDTH-1:0] r_sreg;
    logic             w_new_bit;

    assign o_pred    = ^(r_sreg & TAP_MASK);
    assign o_zero    = (r_sreg == '0);
    assign w_new_bit = i_use_pred ? o_pred : i_si;

    // Shift left, inserting either the received bit (search) or the prediction (flywheel).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_adv) begin
            r_sreg <= {r_sreg[WIDTH-2:0], w_new_bit};
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker with lock/loss FSM and error counting
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK    = DEF_TAP_MASK,
    parameter int               LOCK_CNT    = 8,
    parameter int               WIN         = 16,
    parameter int               LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        si,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt
);

    localparam int FILL_W  = cnt_bits(WIDTH);
    localparam int MATCH_W = cnt_bits(LOCK_CNT);
    localparam int WPOS_W  = cnt_bits(WIN - 1);
    localparam int WERR_W  = cnt_bits(LOSS_THRESH);

    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_CNT);
    localparam logic [WPOS_W-1:0]  WPOS_LAST = WPOS_W'(WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_TGT  = WERR_W'(LOSS_THRESH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FILL_W-1:0]    r_fill;
    logic [MATCH_W-1:0]   r_match;
    logic [WPOS_W-1:0]    r_wpos;
    logic [WERR_W-1:0]    r_werr;
    logic                 r_err;
    logic [15:0]          r_err_cnt;

    logic                 w_pred;
    logic                 w_zero;
    logic                 w_use_pred;
    logic                 w_err_hit;
    logic                 w_mismatch;
    logic                 w_filled;
    logic                 w_hit;
    logic [MATCH_W-1:0]   w_match_inc;
    logic                 w_lock_now;
    logic [WERR_W-1:0]    w_werr_inc;
    logic                 w_loss;
    logic                 w_wrap;
    logic                 w_in_locked;

    lfsr_core #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAP_MASK)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (en),
        .i_use_pred (w_use_pred),
        .i_si       (si),
        .o_pred     (w_pred),
        .o_zero     (w_zero)
    );

    assign w_in_locked = (r_state == ST_LOCKED);
    assign w_mismatch  = si ^ w_pred;
    assign w_filled    = (r_fill == FILL_FULL);
    // A prediction from an all-zero register is meaningless, so it never counts as a match.
    assign w_hit       = w_filled && !w_zero && !w_mismatch;
    assign w_match_inc = r_match + MATCH_W'(1);
    assign w_lock_now  = w_hit && (w_match_inc == MATCH_TGT);
    // The current bit's error is included before comparing, so the wrap bit still counts.
    assign w_werr_inc  = r_werr + WERR_W'(w_mismatch);
    assign w_loss      = (w_werr_inc == WERR_TGT);
    assign w_wrap      = (r_wpos == WPOS_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, load select and error strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_use_pred  = 1'b0;
        w_err_hit   = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (en && w_lock_now) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_use_pred = 1'b1;
                if (en) begin
                    w_err_hit = w_mismatch;
                    if (w_loss) begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
            end
        endcase
    end

    // Fill and consecutive-match counters used while searching; cleared when lock is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill  <= '0;
            r_match <= '0;
        end else if (en) begin
            if (!w_in_locked) begin
                if (!w_filled) begin
                    r_fill <= r_fill + FILL_W'(1);
                end else if (w_hit) begin
                    r_match <= w_match_inc;
                end else begin
                    r_match <= '0;
                end
            end else if (w_loss) begin
                r_fill  <= '0;
                r_match <= '0;
            end
        end
    end

    // Error window: position modulo WIN and errors seen in the current window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wpos <= '0;
            r_werr <= '0;
        end else if (en && w_in_locked) begin
            if (w_loss || w_wrap) begin
                r_wpos <= '0;
                r_werr <= '0;
            end else begin
                r_wpos <= r_wpos + WPOS_W'(1);
                r_werr <= w_werr_inc;
            end
        end
    end

    // Registered error pulse and saturating error count; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_err_hit;
            if (clr_cnt) begin
                r_err_cnt <= '0;
            end else if (w_err_hit && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign locked  = w_in_locked;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule
